traffic_sig_monitor: RTL and testbench
======================================

TRAFFIC_SIG_MONITOR -- requirements
Module: traffic_sig_monitor

Interface
REQ-001 Parameter Y_MIN, default 3: minimum number of consecutive YELLOW samples before RED is legal.
REQ-002 Parameter R2G_MIN, default 2: minimum number of cross-road RED samples before either road may go GREEN.
REQ-003 Parameter WAIT_MAX, default 32, legal range 1..255: number of consecutive CAR_ON samples with country RED that counts as starvation.
REQ-004 CLK  input  1  single clock; all sampling occurs on the rising edge.
REQ-005 CLEAR  input  1  synchronous, active-high reset.
REQ-006 MAIN_SIG  input  2  main highway signal; RED=0, YELLOW=1, GREEN=2, 3 is illegal.
REQ-007 CNTRY_SIG  input  2  country road signal; same encoding as MAIN_SIG.
REQ-008 CAR_ON  input  1  vehicle present on the country road.
REQ-009 FAULT  output  1  sticky fault flag.
REQ-010 FAULT_CODE  output  3  code of the first fault since reset; 0 means none.
REQ-011 ERR_CNT  output  4  count of samples that contained at least one violation; saturates at 15.

Function
REQ-012 The block SHALL be a passive monitor that samples MAIN_SIG, CNTRY_SIG and CAR_ON on every rising CLK edge and drives no signal back to the controller.
REQ-013 The block SHALL register all outputs, updating them on the same edge that samples the violating inputs, so there is no extra latency.
REQ-014 The FSM SHALL have three states: INIT, RUN and FAULTED.
  - INIT -> RUN on the first sample with CLEAR=0.
  - RUN -> FAULTED on any violation.
  - FAULTED is exited only by CLEAR.
REQ-015 The block SHALL keep, per road: a previous-value register, and an 8-bit dwell counter that is set to 1 on a value change, otherwise increments, and saturates at 255.
REQ-016 Code 1 (conflict) SHALL be raised when MAIN_SIG!=RED and CNTRY_SIG!=RED in the same sample.
REQ-017 Code 2 (illegal encoding) SHALL be raised when either input equals 3.
REQ-018 Code 3 (illegal transition) SHALL be raised when a road changes value other than RED->GREEN, GREEN->YELLOW or YELLOW->RED.
REQ-019 Code 4 (short yellow) SHALL be raised on a YELLOW->RED change whose yellow dwell is less than Y_MIN.
REQ-020 Code 5 (no all-red gap) SHALL be raised on a RED->GREEN change of one road while the other road's RED dwell is less than R2G_MIN.
REQ-021 A 8-bit starvation counter SHALL increment while CAR_ON=1 and CNTRY_SIG=RED, clear otherwise, and saturate at 255.
REQ-022 Code 6 (starvation) SHALL be raised only in the sample where the starvation counter reaches WAIT_MAX, i.e. once per waiting episode.
REQ-023 In INIT, only codes 1, 2 and 6 SHALL be evaluated, and the previous-value registers SHALL be loaded.
REQ-024 Transition checks (codes 3-5) SHALL NOT be evaluated in INIT.
REQ-025 When several violations occur in one sample, the lowest code SHALL take priority for FAULT_CODE, and ERR_CNT SHALL increment by exactly 1.
REQ-026 FAULT_CODE SHALL latch only on the RUN->FAULTED transition (or the first fault detected in INIT), and later faults SHALL NOT change it.
REQ-027 Checking SHALL continue in FAULTED, with ERR_CNT incrementing on each violating sample up to 15.
REQ-028 Dwell counters SHALL keep updating across violations, and an illegal value 3 SHALL be stored as the previous value like any other value.

Reset
REQ-029 On any edge with CLEAR=1, the block SHALL set FAULT=0, FAULT_CODE=0, ERR_CNT=0, state=INIT, both dwell counters=0, starvation counter=0 and previous values=RED.
REQ-030 CLEAR SHALL override every other event in the same cycle, including a simultaneous violation, which is ignored.
REQ-031 CLEAR asserted mid-fault SHALL restore the block to the exact post-reset state, so that the next sample with CLEAR=0 is treated as INIT.

Verification
REQ-032 Legal cycle: main G(10) -> Y(3) -> R, then country R(2) -> G(5) -> Y(3) -> R, then main G -> FAULT=0, FAULT_CODE=0, ERR_CNT=0 throughout.
REQ-033 Conflict: MAIN=G with CNTRY driven G for 1 sample -> FAULT=1 and FAULT_CODE=1 on that edge, ERR_CNT=1; code stays 1 after CNTRY returns to R.
REQ-034 Short yellow plus priority:
  - main Y for 2 samples then R -> FAULT_CODE=4.
  - new run with MAIN=3 and CNTRY=G in one sample -> FAULT_CODE=1, ERR_CNT=1.
REQ-035 Starvation: CAR_ON=1 with CNTRY=R for 40 samples and WAIT_MAX=32 -> FAULT_CODE=6 exactly at the 32nd sample; ERR_CNT=1 (no repeat increments).
REQ-036 Saturation and reset: 20 consecutive conflict samples -> ERR_CNT=15; CLEAR for 1 cycle during the violation -> all outputs 0; next legal sample causes no fault.
REQ-037 Missing gap: main Y->R and, on the next sample, country R->G (main RED dwell 1, R2G_MIN=2) -> FAULT_CODE=5.

Source files
------------

// File: rtl/traffic_sig_monitor_if.sv
// Observation bundle between a traffic-light controller and its passive monitor.
// The controller side drives the lamp states; the monitor side reports faults.
interface traffic_sig_monitor_if;
  logic [1:0] main_sig;
  logic [1:0] cntry_sig;
  logic       car_on;
  logic       fault;
  logic [2:0] fault_code;
  logic [3:0] err_cnt;

  modport master (
    output main_sig, cntry_sig, car_on,
    input  fault, fault_code, err_cnt
  );

  modport slave (
    input  main_sig, cntry_sig, car_on,
    output fault, fault_code, err_cnt
  );
endinterface

// File: rtl/traffic_sig_monitor.sv
// Passive safety monitor for a highway / country-road light pair: flags conflicts,
// bad encodings, illegal sequencing, short yellows, missing all-red gaps and starvation.
module traffic_sig_monitor #(
  parameter int unsigned Y_MIN    = 3,
  parameter int unsigned R2G_MIN  = 2,
  parameter int unsigned WAIT_MAX = 32
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  traffic_sig_monitor_if.slave  mon
);

  typedef enum logic [1:0] {INIT, RUN, FAULTED} state_e;

  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YEL = 2'd1;
  localparam logic [1:0] GRN = 2'd2;
  localparam logic [1:0] BAD = 2'd3;

  localparam logic [7:0] Y_MIN_C   = 8'(Y_MIN);
  localparam logic [7:0] R2G_MIN_C = 8'(R2G_MIN);
  localparam logic [7:0] WAIT_C    = 8'(WAIT_MAX);

  localparam logic [2:0] C_NONE     = 3'd0;
  localparam logic [2:0] C_CONFLICT = 3'd1;
  localparam logic [2:0] C_ENCODE   = 3'd2;
  localparam logic [2:0] C_TRANS    = 3'd3;
  localparam logic [2:0] C_SHORTY   = 3'd4;
  localparam logic [2:0] C_NOGAP    = 3'd5;
  localparam logic [2:0] C_STARVE   = 3'd6;

  state_e     state_q, state_d;
  logic       fault_q, fault_d;
  logic [2:0] code_q, code_d;
  logic [3:0] err_q, err_d;
  logic [7:0] starve_q, starve_d;

  // Road 0 is the highway, road 1 the country road.
  logic [1:0] sig       [2];
  logic [1:0] prev_q    [2];
  logic [7:0] dwell_q   [2];
  logic [7:0] dwell_d   [2];
  logic [1:0] bad_trans;
  logic [1:0] short_y;
  logic [1:0] no_gap;

  assign sig[0] = mon.main_sig;
  assign sig[1] = mon.cntry_sig;

  function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
    return (from == RED && to == GRN) || (from == GRN && to == YEL) ||
           (from == YEL && to == RED);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  for (genvar r = 0; r < 2; r++) begin : g_road
    localparam int O = 1 - r;
    logic chg;

    // Checks use the dwell held before this sample, i.e. samples already spent in prev value.
    always_comb begin
      chg          = (sig[r] != prev_q[r]);
      dwell_d[r]   = chg ? 8'd1 : sat_inc8(dwell_q[r]);
      bad_trans[r] = chg && !legal_step(prev_q[r], sig[r]);
      short_y[r]   = chg && (prev_q[r] == YEL) && (sig[r] == RED) && (dwell_q[r] < Y_MIN_C);
      no_gap[r]    = chg && (prev_q[r] == RED) && (sig[r] == GRN) &&
                     !((prev_q[O] == RED) && (dwell_q[O] >= R2G_MIN_C));
    end

    always_ff @(posedge clk_i) begin
      if (clear_i) begin
        prev_q[r]  <= RED;
        dwell_q[r] <= 8'd0;
      end else begin
        prev_q[r]  <= sig[r];
        dwell_q[r] <= dwell_d[r];
      end
    end
  end

  logic       conflict, illegal, waiting, starve_hit, trans_en, viol;
  logic [2:0] code_now;

  always_comb begin
    conflict   = (sig[0] != RED) && (sig[1] != RED);
    illegal    = (sig[0] == BAD) || (sig[1] == BAD);
    waiting    = mon.car_on && (sig[1] == RED);
    starve_d   = waiting ? sat_inc8(starve_q) : 8'd0;
    // Fire only on the sample that reaches the limit, once per waiting episode.
    starve_hit = waiting && (starve_d == WAIT_C) && (starve_q != WAIT_C);
    trans_en   = (state_q != INIT);

    code_now = C_NONE;
    if (conflict)                    code_now = C_CONFLICT;
    else if (illegal)                code_now = C_ENCODE;
    else if (trans_en && |bad_trans) code_now = C_TRANS;
    else if (trans_en && |short_y)   code_now = C_SHORTY;
    else if (trans_en && |no_gap)    code_now = C_NOGAP;
    else if (starve_hit)             code_now = C_STARVE;
    viol = (code_now != C_NONE);
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    err_d   = err_q;
    case (state_q)
      INIT:    state_d = viol ? FAULTED : RUN;
      RUN:     state_d = viol ? FAULTED : RUN;
      FAULTED: state_d = FAULTED;
      default: state_d = INIT;
    endcase
    if (viol) begin
      fault_d = 1'b1;
      if (!fault_q)       code_d = code_now;
      if (err_q != 4'hF)  err_d  = err_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q  <= INIT;
      fault_q  <= 1'b0;
      code_q   <= C_NONE;
      err_q    <= 4'd0;
      starve_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  assign mon.fault      = fault_q;
  assign mon.fault_code = code_q;
  assign mon.err_cnt    = err_q;

endmodule

// File: tb/tb_traffic_sig_monitor.sv
// Scoreboard bench for traffic_sig_monitor: each driven sample queues its expected
// {fault, code, err_cnt}, popped and compared just after the sampling edge.
module tb_traffic_sig_monitor;

  localparam logic [1:0] R = 2'd0;
  localparam logic [1:0] Y = 2'd1;
  localparam logic [1:0] G = 2'd2;
  localparam logic [1:0] X = 2'd3;

  logic clk;
  logic clear;
  int   checks;
  int   errors;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  traffic_sig_monitor_if mif ();

  traffic_sig_monitor #(.Y_MIN(3), .R2G_MIN(2), .WAIT_MAX(32)) dut (
    .clk_i   (clk),
    .clear_i (clear),
    .mon     (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] e(input logic f, input logic [2:0] c, input logic [3:0] n);
    return {f, c, n};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got fault=%0b code=%0d err=%0d, want fault=%0b code=%0d err=%0d",
               tag, obs[7], obs[6:4], obs[3:0], exp[7], exp[6:4], exp[3:0]);
    end
  endtask

  task automatic step(input logic [1:0] m, input logic [1:0] c, input logic car,
                      input logic clr, input logic [7:0] exp, input string tag);
    mif.main_sig  = m;
    mif.cntry_sig = c;
    mif.car_on    = car;
    clear         = clr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    chk(tag_q.pop_front(), {mif.fault, mif.fault_code, mif.err_cnt}, exp_q.pop_front());
  endtask

  task automatic rst_step();
    step(R, R, 1'b0, 1'b1, e(0, 0, 0), "reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mif.main_sig = R; mif.cntry_sig = R; mif.car_on = 1'b0; clear = 1'b1;
    @(posedge clk);
    #1;
    rst_step();

    // Legal full cycle, both roads, minimum legal yellow and all-red gaps.
    for (int i = 0; i < 10; i++) step(G, R, 0, 0, e(0, 0, 0), "legal_mainG");
    for (int i = 0; i < 3; i++)  step(Y, R, 0, 0, e(0, 0, 0), "legal_mainY");
    for (int i = 0; i < 2; i++)  step(R, R, 0, 0, e(0, 0, 0), "legal_gap1");
    for (int i = 0; i < 5; i++)  step(R, G, 0, 0, e(0, 0, 0), "legal_cntryG");
    for (int i = 0; i < 3; i++)  step(R, Y, 0, 0, e(0, 0, 0), "legal_cntryY");
    for (int i = 0; i < 2; i++)  step(R, R, 0, 0, e(0, 0, 0), "legal_gap2");
    step(G, R, 0, 0, e(0, 0, 0), "legal_mainG2");

    // Conflict; the country G->R afterwards is itself illegal and counts but keeps code 1.
    rst_step();
    step(G, R, 0, 0, e(0, 0, 0), "conf_pre");
    step(G, R, 0, 0, e(0, 0, 0), "conf_pre");
    step(G, G, 0, 0, e(1, 1, 1), "conf_hit");
    step(G, R, 0, 0, e(1, 1, 2), "conf_back");
    step(G, R, 0, 0, e(1, 1, 2), "conf_hold");

    // Short yellow.
    rst_step();
    for (int i = 0; i < 3; i++) step(G, R, 0, 0, e(0, 0, 0), "shorty_G");
    step(Y, R, 0, 0, e(0, 0, 0), "shorty_Y1");
    step(Y, R, 0, 0, e(0, 0, 0), "shorty_Y2");
    step(R, R, 0, 0, e(1, 4, 1), "shorty_hit");

    // Priority: illegal encoding and conflict together in the INIT sample.
    rst_step();
    step(X, G, 0, 0, e(1, 1, 1), "prio_hit");

    // Starvation at exactly the 32nd waiting sample, no repeat count.
    rst_step();
    for (int i = 1; i <= 40; i++)
      step(G, R, 1, 0, (i < 32) ? e(0, 0, 0) : e(1, 6, 1), "starve");
    step(G, R, 0, 0, e(1, 6, 1), "starve_end");

    // ERR_CNT saturation, then CLEAR during a violation, then clean restart.
    rst_step();
    for (int i = 1; i <= 20; i++)
      step(G, G, 0, 0, e(1, 1, (i < 15) ? 4'(i) : 4'd15), "sat");
    step(G, G, 0, 1, e(0, 0, 0), "clr_in_viol");
    step(G, R, 0, 0, e(0, 0, 0), "post_clr_init");
    step(G, R, 0, 0, e(0, 0, 0), "post_clr_run");

    // Missing all-red gap: country goes G one sample after main turns R.
    rst_step();
    for (int i = 0; i < 3; i++) step(G, R, 0, 0, e(0, 0, 0), "gap_G");
    for (int i = 0; i < 3; i++) step(Y, R, 0, 0, e(0, 0, 0), "gap_Y");
    step(R, R, 0, 0, e(0, 0, 0), "gap_R");
    step(R, G, 0, 0, e(1, 5, 1), "gap_hit");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
